// File: rtl/io_pkg.sv
// Shared constants for the switch-input block: register addresses and debounce defaults.
package io_pkg;

    localparam logic [1:0] ADDR_PORT0  = 2'd0;
    localparam logic [1:0] ADDR_PORT1  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 20;

endpackage

// File: rtl/debounce_port.sv
// One switch port: two-flop synchroniser, candidate register, hold counter and stable value.
// accept is high for the single cycle in which stable is about to take the candidate.
module debounce_port
    import io_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             mem_clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             accept
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        accept = (sync_q2 == cand) && (cand != stable) && (cnt == CNT_LAST);
    end

    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            cand    <= '0;
            cnt     <= '0;
            stable  <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 != cand) begin
                cand <= sync_q2;
                cnt  <= '0;
            end else if (cand != stable) begin
                if (accept) begin
                    stable <= cand;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/io_input_debounce.sv
// Two debounced switch ports with sticky change flags and a registered read port
// for the data-memory I/O decode; reading the status register clears the flags.
module io_input_debounce
    import io_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             mem_clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw_in0,
    input  logic [WIDTH-1:0] raw_in1,
    input  logic             rd_en,
    input  logic [1:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic [WIDTH-1:0] in_port0,
    output logic [WIDTH-1:0] in_port1,
    output logic [1:0]       chg
);

    logic [1:0]  accept;
    logic [1:0]  chg_clr;
    logic [31:0] rd_next;

    debounce_port #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_port0 (
        .mem_clk (mem_clk),
        .resetn  (resetn),
        .raw     (raw_in0),
        .stable  (in_port0),
        .accept  (accept[0])
    );

    debounce_port #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_port1 (
        .mem_clk (mem_clk),
        .resetn  (resetn),
        .raw     (raw_in1),
        .stable  (in_port1),
        .accept  (accept[1])
    );

    always_comb begin
        rd_next = 32'h0;
        case (rd_addr)
            ADDR_PORT0:  rd_next = 32'(in_port0);
            ADDR_PORT1:  rd_next = 32'(in_port1);
            ADDR_STATUS: rd_next = 32'(chg);
            default:     rd_next = 32'h0;
        endcase
    end

    assign chg_clr = {2{rd_en && (rd_addr == ADDR_STATUS)}};

    // A new acceptance on the clearing edge must not be lost, so set beats clear.
    always_ff @(posedge mem_clk) begin
        if (!resetn) begin
            chg     <= '0;
            rd_data <= '0;
        end else begin
            chg <= (chg & ~chg_clr) | accept;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce with a run-length reference model checked every cycle.
module tb_io_input_debounce;

    localparam int D = 4;

    logic        mem_clk = 1'b0;
    logic        resetn  = 1'b0;
    logic [3:0]  raw_in0 = 4'h0;
    logic [3:0]  raw_in1 = 4'h0;
    logic        rd_en   = 1'b0;
    logic [1:0]  rd_addr = 2'd0;
    logic [31:0] rd_data;
    logic [3:0]  in_port0;
    logic [3:0]  in_port1;
    logic [1:0]  chg;

    io_input_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .mem_clk  (mem_clk),
        .resetn   (resetn),
        .raw_in0  (raw_in0),
        .raw_in1  (raw_in1),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .chg      (chg)
    );

    always #5 mem_clk = ~mem_clk;

    // Reference model: raw is seen 2 edges late; a value is accepted on the
    // (D+1)-th consecutive edge on which the synchronised value equals it.
    logic [3:0]  m_d1 [2];
    logic [3:0]  m_d2 [2];
    logic [3:0]  run_val [2];
    int          run_len [2];
    logic [3:0]  m_stable [2];
    logic [1:0]  m_chg = 2'b00;
    logic [31:0] m_rd  = 32'h0;
    logic [3:0]  rawv [2];
    logic [1:0]  acc;
    logic [3:0]  st_pre [2];
    logic [1:0]  chg_pre;

    initial begin
        for (int p = 0; p < 2; p++) begin
            m_d1[p] = '0; m_d2[p] = '0; run_val[p] = '0; run_len[p] = 0; m_stable[p] = '0;
        end
    end

    always @(posedge mem_clk) begin
        rawv[0] = raw_in0;
        rawv[1] = raw_in1;
        if (!resetn) begin
            for (int p = 0; p < 2; p++) begin
                m_d1[p] = '0; m_d2[p] = '0; run_val[p] = '0; run_len[p] = 0; m_stable[p] = '0;
            end
            m_chg = 2'b00;
            m_rd  = 32'h0;
        end else begin
            chg_pre   = m_chg;
            st_pre[0] = m_stable[0];
            st_pre[1] = m_stable[1];
            for (int p = 0; p < 2; p++) begin
                if (m_d2[p] == run_val[p]) run_len[p] = run_len[p] + 1;
                else begin
                    run_val[p] = m_d2[p];
                    run_len[p] = 1;
                end
                acc[p] = (run_val[p] != m_stable[p]) && (run_len[p] == D + 1);
                if (acc[p]) m_stable[p] = run_val[p];
                m_d2[p] = m_d1[p];
                m_d1[p] = rawv[p];
            end
            if (rd_en) begin
                case (rd_addr)
                    2'd0:    m_rd = {28'h0, st_pre[0]};
                    2'd1:    m_rd = {28'h0, st_pre[1]};
                    2'd2:    m_rd = {30'h0, chg_pre};
                    default: m_rd = 32'h0;
                endcase
            end
            if (rd_en && rd_addr == 2'd2) m_chg = (m_chg & ~2'b11) | acc;
            else                          m_chg = m_chg | acc;
        end
    end

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;
    bit watch3   = 1'b0;
    bit saw3     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model in_port0", {28'h0, in_port0}, {28'h0, m_stable[0]});
        chk("model in_port1", {28'h0, in_port1}, {28'h0, m_stable[1]});
        chk("model chg",      {30'h0, chg},      {30'h0, m_chg});
        chk("model rd_data",  rd_data,           m_rd);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge mem_clk);
            if (check_en) compare_model();
            if (watch3 && in_port0 == 4'h3) saw3 = 1'b1;
        end
    endtask

    task automatic rd(input logic [1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step(1);
        rd_en   = 1'b0;
    endtask

    initial begin
        step(2);
        resetn   = 1'b1;
        check_en = 1'b1;
        step(1);
        chk("reset in_port0", {28'h0, in_port0}, 32'h0);
        chk("reset in_port1", {28'h0, in_port1}, 32'h0);
        chk("reset chg",      {30'h0, chg},      32'h0);
        chk("reset rd_data",  rd_data,           32'h0);
        rd(2'd2);
        chk("idle status read", rd_data, 32'h0);

        raw_in0 = 4'hA;
        step(6);
        chk("p0 not yet at 6 edges", {28'h0, in_port0}, 32'h0);
        step(1);
        chk("p0 accepted at 7 edges", {28'h0, in_port0}, 32'hA);
        chk("p0 chg set", {30'h0, chg}, 32'h1);
        rd(2'd0);
        chk("read addr0", rd_data, 32'h0000000A);
        rd(2'd2);
        chk("status read p0", rd_data, 32'h1);
        chk("chg cleared", {30'h0, chg}, 32'h0);

        raw_in1 = 4'h5;
        step(3);
        raw_in1 = 4'h0;
        step(10);
        chk("glitch ignored port1", {28'h0, in_port1}, 32'h0);
        chk("glitch no flag", {30'h0, chg}, 32'h0);
        raw_in1 = 4'h5;
        step(6);
        chk("p1 not yet at 6 edges", {28'h0, in_port1}, 32'h0);
        step(1);
        chk("p1 accepted", {28'h0, in_port1}, 32'h5);
        chk("p1 chg set", {30'h0, chg}, 32'h2);
        rd(2'd2);
        chk("status read p1", rd_data, 32'h2);

        raw_in0 = 4'h0;
        step(10);
        rd(2'd2);
        chk("p0 back to 0 flag", rd_data, 32'h1);
        raw_in0 = 4'h3;
        step(4);
        raw_in0 = 4'h6;
        watch3  = 1'b1;
        step(6);
        chk("restart not yet", {28'h0, in_port0}, 32'h0);
        step(1);
        chk("restart accepted 6", {28'h0, in_port0}, 32'h6);
        chk("restart chg", {30'h0, chg}, 32'h1);
        chk("never saw 3", {31'h0, saw3}, 32'h0);
        watch3 = 1'b0;

        raw_in1 = 4'h0;
        step(6);
        rd(2'd2);
        chk("set-wins rd_data", rd_data, 32'h1);
        chk("set-wins chg", {30'h0, chg}, 32'h2);
        chk("set-wins in_port1", {28'h0, in_port1}, 32'h0);
        rd(2'd2);
        chk("set-wins followup", rd_data, 32'h2);

        raw_in0 = 4'h1;
        raw_in1 = 4'h2;
        step(7);
        chk("both chg", {30'h0, chg}, 32'h3);
        rd(2'd3);
        chk("read addr3", rd_data, 32'h0);
        rd(2'd1);
        chk("read addr1", rd_data, 32'h2);
        chk("reads keep chg", {30'h0, chg}, 32'h3);

        raw_in0 = 4'h9;
        step(4);
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        chk("midreset in_port0", {28'h0, in_port0}, 32'h0);
        chk("midreset in_port1", {28'h0, in_port1}, 32'h0);
        chk("midreset chg",      {30'h0, chg},      32'h0);
        chk("midreset rd_data",  rd_data,           32'h0);
        step(6);
        chk("post-reset not yet", {28'h0, in_port0}, 32'h0);
        step(1);
        chk("post-reset p0", {28'h0, in_port0}, 32'h9);
        chk("post-reset p1", {28'h0, in_port1}, 32'h2);
        chk("post-reset chg", {30'h0, chg}, 32'h3);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
